// File: rtl/mac_4bit_ctrl.sv
// Multiply-accumulate controller around an external 4x4 combinational multiplier.
// Optional macro MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mac_4bit_ctrl #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [3:0]       i_op1,
  input  logic [3:0]       i_op2,
  output logic             o_ready,
  output logic [3:0]       o_mult_op1,
  output logic [3:0]       o_mult_op2,
  input  logic [7:0]       i_mult,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_nxt;
  logic             s1_vld;
  logic             s2_vld;
  logic [7:0]       prod_q;
  logic [ACC_W:0]   sum;
  logic             carry;

  assign cnt_nxt = cnt_q + 1'b1;
  assign sum     = {1'b0, o_acc} + {{(ACC_W - 7){1'b0}}, prod_q};
  assign carry   = sum[ACC_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      prod_q     <= '0;
      o_mult_op1 <= '0;
      o_mult_op2 <= '0;
      o_acc      <= '0;
      o_ovf      <= 1'b0;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      s1_vld <= 1'b0;
      s2_vld <= s1_vld;
      if (s1_vld) prod_q <= i_mult;

      if (s2_vld) begin
        o_ovf <= o_ovf | carry;
`ifdef MAC_SAT_EN
        // once saturated, the accumulator is pinned for the rest of the burst
        if (carry || o_ovf) o_acc <= '1;
        else                o_acc <= sum[ACC_W-1:0];
`else
        o_acc <= sum[ACC_W-1:0];
`endif
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            o_acc <= '0;
            o_ovf <= 1'b0;
            cnt_q <= '0;
            if (i_len != '0) begin
              len_q   <= i_len;
              state   <= RUN;
              o_ready <= 1'b1;
              o_busy  <= 1'b1;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_valid) begin
            o_mult_op1 <= i_op1;
            o_mult_op2 <= i_op2;
            s1_vld     <= 1'b1;
            cnt_q      <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state   <= DRAIN;
              o_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // last product is in stage 2 and nothing is behind it
          if (s2_vld && !s1_vld) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_4bit_ctrl.sv
// Directed bench for mac_4bit_ctrl: a 12-bit and an 8-bit accumulator instance share stimulus.
module tb_mac_4bit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       valid;
  logic [3:0] op1, op2;

  logic        ready_a, busy_a, done_a, ovf_a;
  logic [3:0]  mop1_a, mop2_a;
  logic [7:0]  mult_a;
  logic [11:0] acc_a;

  logic        ready_b, busy_b, done_b, ovf_b;
  logic [3:0]  mop1_b, mop2_b;
  logic [7:0]  mult_b;
  logic [7:0]  acc_b;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n0;

  always #5 clk = ~clk;

  // reference multiplier
  assign mult_a = 8'(mop1_a) * 8'(mop2_a);
  assign mult_b = 8'(mop1_b) * 8'(mop2_b);

  always @(posedge clk) if (!rst && valid && ready_a) n_acc++;

  mac_4bit_ctrl #(.ACC_W(12), .LEN_W(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_valid(valid),
    .i_op1(op1), .i_op2(op2), .o_ready(ready_a), .o_mult_op1(mop1_a),
    .o_mult_op2(mop2_a), .i_mult(mult_a), .o_acc(acc_a), .o_busy(busy_a),
    .o_done(done_a), .o_ovf(ovf_a)
  );

  mac_4bit_ctrl #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_valid(valid),
    .i_op1(op1), .i_op2(op2), .o_ready(ready_b), .o_mult_op1(mop1_b),
    .o_mult_op2(mop2_b), .i_mult(mult_b), .o_acc(acc_b), .o_busy(busy_b),
    .o_done(done_b), .o_ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pair(input logic [3:0] a, input logic [3:0] b);
    valid = 1'b1; op1 = a; op2 = b;
    step();
    valid = 1'b0;
  endtask

  task automatic begin_burst(input logic [3:0] l);
    start = 1'b1; len = l;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; op1 = '0; op2 = '0;
    step(); step();
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_busy",  32'(busy_a),  0);
    chk("rst_done",  32'(done_a),  0);
    chk("rst_ovf",   32'(ovf_a),   0);
    chk("rst_acc",   32'(acc_a),   0);
    chk("rst_mop",   32'({mop1_a, mop2_a}), 0);
    rst = 1'b0;
    step();

    // burst of 3, back-to-back
    n0 = n_acc;
    begin_burst(4'd3);
    chk("t1_ready_run", 32'(ready_a), 1);
    chk("t1_busy_run",  32'(busy_a),  1);
    valid = 1'b1; op1 = 4'd3;  op2 = 4'd5;  step();
    op1 = 4'd15; op2 = 4'd15; step();
    op1 = 4'd0;  op2 = 4'd9;  step();
    valid = 1'b0;
    chk("t1_ready_drain", 32'(ready_a), 0);
    chk("t1_done_e1",     32'(done_a),  0);
    chk("t1_busy_drain",  32'(busy_a),  1);
    step();
    chk("t1_done_e1b",    32'(done_a),  0);
    step();
    chk("t1_done",  32'(done_a), 1);
    chk("t1_acc",   32'(acc_a),  240);
    chk("t1_ovf",   32'(ovf_a),  0);
    chk("t1_busy",  32'(busy_a), 0);
    chk("t1_nacc",  32'(n_acc - n0), 3);
    step();
    chk("t1_done_once", 32'(done_a), 0);
    chk("t1_acc_hold",  32'(acc_a),  240);

    // burst of 2 with bubbles
    n0 = n_acc;
    begin_burst(4'd2);
    pair(4'd7, 4'd6);
    step(); step(); step();
    chk("t2_ready_bubble", 32'(ready_a), 1);
    pair(4'd2, 4'd9);
    step(); step();
    chk("t2_done", 32'(done_a), 1);
    chk("t2_acc",  32'(acc_a),  60);
    chk("t2_nacc", 32'(n_acc - n0), 2);
    step();

    // zero-length burst
    n0 = n_acc;
    start = 1'b1; len = 4'd0; valid = 1'b1; op1 = 4'd5; op2 = 4'd5;
    step();
    start = 1'b0; valid = 1'b0;
    chk("t3_done",  32'(done_a),  1);
    chk("t3_acc",   32'(acc_a),   0);
    chk("t3_ready", 32'(ready_a), 0);
    step();
    chk("t3_done_once", 32'(done_a), 0);
    chk("t3_nacc", 32'(n_acc - n0), 0);

    // overflow on the 8-bit instance
    begin_burst(4'd2);
    valid = 1'b1; op1 = 4'd15; op2 = 4'd15; step(); step();
    valid = 1'b0;
    step(); step();
    chk("t4_done",    32'(done_b), 1);
    chk("t4_acc12",   32'(acc_a),  450);
    chk("t4_ovf12",   32'(ovf_a),  0);
`ifdef MAC_SAT_EN
    chk("t4_acc8",    32'(acc_b),  255);
`else
    chk("t4_acc8",    32'(acc_b),  194);
`endif
    chk("t4_ovf8",    32'(ovf_b),  1);
    step();
    chk("t4_ovf8_hold", 32'(ovf_b), 1);

    // reset in the middle of a burst
    begin_burst(4'd4);
    pair(4'd2, 4'd2);
    step(); step();
    chk("t5_acc_pre", 32'(acc_a), 4);
    rst = 1'b1;
    step();
    chk("t5_ready", 32'(ready_a), 0);
    chk("t5_busy",  32'(busy_a),  0);
    chk("t5_done",  32'(done_a),  0);
    chk("t5_acc",   32'(acc_a),   0);
    chk("t5_ovf8",  32'(ovf_b),   0);
    chk("t5_mop",   32'({mop1_a, mop2_a}), 0);
    rst = 1'b0;
    step();
    chk("t5_idle_ready", 32'(ready_a), 0);
    begin_burst(4'd1);
    pair(4'd2, 4'd3);
    step(); step();
    chk("t5_done2", 32'(done_a), 1);
    chk("t5_acc2",  32'(acc_a),  6);
    step();

    // stray valid in IDLE, stray start in RUN and DONE
    n0 = n_acc;
    valid = 1'b1; op1 = 4'd4; op2 = 4'd4;
    step();
    valid = 1'b0;
    chk("t6_idle_ready", 32'(ready_a), 0);
    chk("t6_idle_busy",  32'(busy_a),  0);
    chk("t6_idle_mop",   32'({mop1_a, mop2_a}), 32'h23);
    begin_burst(4'd2);
    pair(4'd1, 4'd2);
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    chk("t6_run_ready", 32'(ready_a), 1);
    pair(4'd3, 4'd3);
    step(); step();
    chk("t6_done", 32'(done_a), 1);
    chk("t6_acc",  32'(acc_a),  11);
    chk("t6_nacc", 32'(n_acc - n0), 2);
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    chk("t6_done_start_busy",  32'(busy_a),  0);
    chk("t6_done_start_ready", 32'(ready_a), 0);
    chk("t6_acc_hold",         32'(acc_a),   11);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_4bit_ctrl.md
# mac_4bit_ctrl

Sequential multiply-accumulate controller for the ALU datapath. It sits around the combinational 4x4 unsigned array multiplier: it feeds the multiplier from a registered operand stage and consumes its 8-bit product. It accepts a burst of operand pairs over a valid/ready handshake and sums their products into an accumulator. It reports completion with a one-cycle done pulse.

## Interface
- ACC_W, 12, accumulator width; must be >= 8
- LEN_W, 4, width of burst-length input; max burst 2^LEN_W-1 pairs

- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  begin burst; sampled in IDLE only
- i_len  input  LEN_W  number of operand pairs in burst; latched on start
- i_valid  input  1  operand pair present on i_op1/i_op2
- i_op1  input  4  multiplicand
- i_op2  input  4  multiplier
- o_ready  output  1  block accepts a pair this cycle
- o_mult_op1  output  4  registered operand to multiplier i_op1
- o_mult_op2  output  4  registered operand to multiplier i_op2
- i_mult  input  8  product returned combinationally by multiplier
- o_acc  output  ACC_W  accumulated sum; held after done until next start
- o_busy  output  1  high in RUN and DRAIN
- o_done  output  1  one-cycle completion pulse
- o_ovf  output  1  sticky overflow flag for current burst

## Operation
- Reset: state IDLE. o_ready, o_busy, o_done, o_ovf = 0. o_acc = 0. o_mult_op1/2 = 0. Pipeline valid flags and counter = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on i_start with i_len != 0, latch i_len, clear o_acc, o_ovf and count, then go to RUN. On i_start with i_len == 0, clear o_acc/o_ovf and go to DONE. i_valid is ignored.
- RUN: o_ready = 1. A pair is accepted on an edge where i_valid & o_ready. Accepting loads o_mult_op1/2, sets stage-1 valid and increments count. When the accepted pair is the last (count+1 == len), go to DRAIN; o_ready drops the next cycle.
- Pipeline: stage 1 holds the operand registers, which drive the multiplier. Stage 2 registers i_mult when stage-1 valid. Stage 3 adds the zero-extended stage-2 product into o_acc when stage-2 valid.
- DRAIN: o_ready = 0. Go to DONE on the edge where the final product is added to o_acc.
- DONE: o_done = 1 for exactly one cycle, then IDLE. o_acc and o_ovf hold.
- i_start is ignored outside IDLE, including in DONE.
- Overflow: o_ovf is set when the ACC_W-bit add carries out. It stays set until the next start or reset. Behaviour of o_acc on overflow is set under Configuration.
- Reset mid-burst (any state): on the reset edge all state returns to reset values. The partial burst is discarded.

## Timing
- Throughput: one pair per cycle while i_valid is held high in RUN. Bubbles on i_valid are allowed.
- Latency: last pair accepted on edge E0. Product is registered at E1. o_acc is final and o_done is high after E2, for one cycle.
- Zero-length burst: o_done is high in the cycle after the start edge, with o_acc = 0.
- The multiplier path is combinational from o_mult_op* to i_mult. It must settle within one cycle.

## Configuration
- MAC_SAT_EN defined: on a carry-out, o_acc saturates to all ones and stays saturated for the rest of the burst. o_ovf = 1.
- MAC_SAT_EN undefined: o_acc wraps modulo 2^ACC_W. o_ovf = 1.

## Test plan
- Start, len=3, pairs (3,5),(15,15),(0,9) back-to-back -> o_acc=240, o_ovf=0, o_done one pulse 2 edges after third acceptance, o_ready low from that point.
- Start, len=2, pairs (7,6) then 3 idle cycles then (2,9) -> o_acc=60. Exactly 2 acceptances counted.
- Start with len=0 -> o_done high the next cycle, o_acc=0, no o_ready assertion.
- ACC_W=8, len=2, pairs (15,15),(15,15) -> with MAC_SAT_EN o_acc=255, o_ovf=1; without it o_acc=194, o_ovf=1.
- len=4, reset asserted after first acceptance -> next cycle all outputs 0 and state IDLE. A new len=1 burst (2,3) then gives o_acc=6.
- i_valid pulsed in IDLE, and i_start pulsed during RUN -> no acceptance, len/count unchanged, burst completes normally.
